// File: rtl/ifetch_pq_pkg.sv
// Shared fetch-stage types for the bexkat1 prefetching fetch unit.
// Entry layout is {err, word}; err entries carry a zero word.
package bexkat1Def;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_FETCH2,
        S_FAULT
    } fetch_state_t;

    localparam int INSN_LONG_BIT = 0;
    localparam int FETCH_ENTRY_W = 33;

    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/wb_bus.sv
// Pipelined Wishbone bus bundle, master and slave views.
// dat_i carries read data towards the master.
interface wb_bus;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, adr, we, sel, dat_o,
        input  dat_i, ack, err, stall
    );

    modport slave (
        input  cyc, stb, adr, we, sel, dat_o,
        output dat_i, ack, err, stall
    );
endinterface

// File: rtl/ifetch_pq_fifo.sv
// Prefetch buffer: first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop frees the slot.
module ifetch_pq_fifo #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 33
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              empty,
    output logic [AWIDTH:0]   count
);
    localparam int PW = AWIDTH + 1;

    logic [DWIDTH-1:0] mem [2**AWIDTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              wr_en;
    logic              rd_en;

    assign count = wr_ptr - rd_ptr;
    assign empty = count == '0;
    assign full  = count[AWIDTH];
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr[AWIDTH-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AWIDTH-1:0]] <= wdata;
    end

endmodule

// File: rtl/ifetch_pq.sv
// Prefetching fetch unit: credit-limited pipelined Wishbone reads,
// redirect with stale-response discard, 32/64-bit instruction assembly.
module ifetch_pq #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_OUT  = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_bus.master       bus,
    input  logic        pc_set,
    input  logic [31:0] pc_in,
    input  logic        stall_i,
    output logic [63:0] ir,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic        fault,
    output logic [31:0] fault_adr
);
    import bexkat1Def::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;

    fetch_state_t  state;
    fetch_entry_t  wr_entry;
    fetch_entry_t  rd_entry;
    logic [31:0]   adr;
    logic [31:0]   fetch_ptr;
    logic [31:0]   low;
    logic [31:0]   low_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [SW-1:0] credit_use;
    logic          stb;
    logic          req_acc;
    logic          resp;
    logic          push;
    logic          pop;
    logic          empty;
    logic          is_long;
    logic          pop_err;
    logic          pop_hi;
    logic          pop_lo;

    // Credits cover both in-flight reads and buffered words.
    assign credit_use = {1'b0, outstanding} + {1'b0, count};

    assign stb = state != S_RESET
              && state != S_FAULT
              && !pc_set
              && outstanding < CW'(MAX_OUT)
              && credit_use < SW'(DEPTH);

    assign req_acc = stb && !bus.stall;
    assign resp    = bus.ack || bus.err;
    assign push    = resp && discard == '0 && !pc_set;

    assign wr_entry.err  = bus.err;
    assign wr_entry.word = bus.err ? 32'h0 : bus.dat_i;

    assign pop = !stall_i && !pc_set && !empty
              && (state == S_FETCH || state == S_FETCH2);

    assign is_long = rd_entry.word[INSN_LONG_BIT];
    assign pop_err = pop && rd_entry.err;
    assign pop_hi  = pop && !rd_entry.err && state == S_FETCH2;
    assign pop_lo  = pop && !rd_entry.err && state == S_FETCH && is_long;

    assign bus.cyc   = stb || outstanding != '0;
    assign bus.stb   = stb;
    assign bus.adr   = adr;
    assign bus.we    = 1'b0;
    assign bus.sel   = 4'hf;
    assign bus.dat_o = 32'h0;

    ifetch_pq_fifo #(
        .AWIDTH (AW),
        .DWIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i || pc_set),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_RESET;
            adr         <= RESET_PC;
            fetch_ptr   <= RESET_PC;
            low         <= '0;
            low_pc      <= '0;
            outstanding <= '0;
            discard     <= '0;
            ir          <= '0;
            ir_valid    <= 1'b0;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fault_adr   <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_acc) - CW'(resp);
            if (req_acc) adr <= adr + 32'd4;
            if (pc_set) begin
                discard   <= outstanding - CW'(resp);
                adr       <= pc_in;
                fetch_ptr <= pc_in;
                ir        <= '0;
                ir_valid  <= 1'b0;
                state     <= S_FETCH;
                fault     <= 1'b0;
            end else begin
                if (resp && discard != '0) discard <= discard - CW'(1);
                if (state == S_RESET) state <= S_FETCH;
                if (!stall_i) begin
                    if (pop) fetch_ptr <= fetch_ptr + 32'd4;
                    unique case (1'b1)
                        !pop: begin
                            ir       <= '0;
                            ir_valid <= 1'b0;
                        end
                        pop_err: begin
                            fault     <= 1'b1;
                            fault_adr <= fetch_ptr;
                            ir        <= '0;
                            ir_valid  <= 1'b0;
                            state     <= S_FAULT;
                        end
                        pop_hi: begin
                            ir       <= {rd_entry.word, low};
                            ir_valid <= 1'b1;
                            pc       <= low_pc;
                            state    <= S_FETCH;
                        end
                        pop_lo: begin
                            low      <= rd_entry.word;
                            low_pc   <= fetch_ptr;
                            ir       <= '0;
                            ir_valid <= 1'b0;
                            state    <= S_FETCH2;
                        end
                        default: begin
                            ir       <= {32'h0, rd_entry.word};
                            ir_valid <= 1'b1;
                            pc       <= fetch_ptr;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch_pq.sv
// Scoreboard bench for ifetch_pq with an in-order pipelined slave model.
// Stimulus queues expected instructions; a monitor checks each ir_valid.
module tb_ifetch_pq;

    typedef struct {
        logic [63:0] ir;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] adr;
        int          ready;
    } req_t;

    logic        clk      = 1'b0;
    logic        rst_i    = 1'b1;
    logic        pc_set   = 1'b0;
    logic [31:0] pc_in    = 32'h0;
    logic        stall_i  = 1'b1;
    logic [63:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] fault_adr;

    int          checks    = 0;
    int          failures  = 0;
    int          lat       = 0;
    int          req_total = 0;
    int          cyc_n     = 0;
    logic [31:0] err_adr   = 32'hFFFF_FFFF;

    exp_t        sb[$];
    req_t        pend[$];
    logic [31:0] req_log[$];
    logic [31:0] mem_ovr[logic [31:0]];

    wb_bus bus_if();

    ifetch_pq #(
        .DEPTH    (8),
        .MAX_OUT  (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus_if),
        .pc_set    (pc_set),
        .pc_in     (pc_in),
        .stall_i   (stall_i),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .fault     (fault),
        .fault_adr (fault_adr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {a[29:0], 2'b00} + 32'h10;
    endfunction

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_ins(input logic [63:0] i, input logic [31:0] p);
        sb.push_back('{ir: i, pc: p});
    endtask

    task automatic redirect(input logic [31:0] a);
        sb.delete();
        pc_set = 1'b1;
        pc_in  = a;
        @(negedge clk);
        pc_set = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        stall_i = 1'b0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        stall_i = 1'b1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d pending after %0d cycles, required 0",
                     name, sb.size(), n);
            sb.delete();
        end
    endtask

    // Slave: accepts every request, answers in order after lat cycles
    initial begin
        bus_if.ack   = 1'b0;
        bus_if.err   = 1'b0;
        bus_if.dat_i = 32'h0;
        bus_if.stall = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_i) begin
                pend.delete();
            end else begin
                if (bus_if.ack || bus_if.err) void'(pend.pop_front());
                if (bus_if.cyc && bus_if.stb && !bus_if.stall) begin
                    pend.push_back('{adr: bus_if.adr, ready: cyc_n + lat});
                    req_log.push_back(bus_if.adr);
                    req_total++;
                end
            end
            cyc_n++;
            #1;
            bus_if.ack   = 1'b0;
            bus_if.err   = 1'b0;
            bus_if.dat_i = 32'h0;
            if (pend.size() > 0 && pend[0].ready < cyc_n) begin
                if (pend[0].adr == err_adr) begin
                    bus_if.err = 1'b1;
                end else begin
                    bus_if.ack   = 1'b1;
                    bus_if.dat_i = mem_rd(pend[0].adr);
                end
            end
        end
    end

    // Monitor: every freshly loaded ir_valid must match the queue head
    initial begin
        logic stall_s;
        logic rst_s;
        exp_t e;
        forever begin
            @(posedge clk);
            stall_s = stall_i;
            rst_s   = rst_i;
            #1;
            if (!rst_s && !stall_s && ir_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ir: got ir=%h pc=%h required none",
                             ir, pc);
                end else begin
                    e = sb.pop_front();
                    chk("ir_pc", {ir, pc}, {e.ir, e.pc});
                end
            end
        end
    end

    initial begin
        int n;
        int base;
        int mx;

        repeat (3) @(negedge clk);
        chk("rst_ir", 96'(ir), 96'(0));
        chk("rst_valid", 96'(ir_valid), 96'(0));
        chk("rst_pc", 96'(pc), 96'(0));
        chk("rst_fault", {63'h0, fault, fault_adr}, 96'(0));
        chk("rst_cyc_stb", 96'({bus_if.cyc, bus_if.stb}), 96'(0));
        chk("rst_adr", 96'(bus_if.adr), 96'(0));

        // Zero-wait stream from reset
        expect_ins(64'h10, 32'h0);
        expect_ins(64'h20, 32'h4);
        expect_ins(64'h30, 32'h8);
        expect_ins(64'h40, 32'hC);
        stall_i = 1'b0;
        rst_i   = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (ir_valid) break;
        end
        chk("first_ir_latency", 96'(n), 96'(4));
        @(negedge clk);
        drain("t1", 40);
        repeat (3) @(negedge clk);
        chk("hold_ir", 96'(ir), 96'(64'h40));
        chk("hold_valid_pc", 96'({ir_valid, pc}), 96'({1'b1, 32'hC}));
        chk("adr_seq", {req_log[0], req_log[1], req_log[2]},
            {32'h0, 32'h4, 32'h8});

        // 64-bit instruction assembly
        mem_ovr[32'h0] = 32'h0000_0001;
        mem_ovr[32'h4] = 32'hDEAD_BEEF;
        redirect(32'h0);
        expect_ins(64'hDEADBEEF_00000001, 32'h0);
        expect_ins(64'h30, 32'h8);
        expect_ins(64'h40, 32'hC);
        drain("t2", 40);
        mem_ovr.delete();

        // Slow slave under decode stall: credit limits
        lat = 10;
        redirect(32'h300);
        base = req_total;
        mx = 0;
        repeat (40) begin
            @(negedge clk);
            if (pend.size() > mx) mx = pend.size();
        end
        chk("max_outstanding", 96'(mx), 96'(4));
        chk("total_requests", 96'(req_total - base), 96'(8));
        chk("stalled_no_ir", 96'(ir_valid), 96'(0));
        lat = 0;
        expect_ins(64'hC10, 32'h300);
        expect_ins(64'hC20, 32'h304);
        expect_ins(64'hC30, 32'h308);
        expect_ins(64'hC40, 32'h30C);
        expect_ins(64'hC50, 32'h310);
        expect_ins(64'hC60, 32'h314);
        expect_ins(64'hC70, 32'h318);
        expect_ins(64'hC80, 32'h31C);
        drain("t3", 60);

        // Redirect with three reads in flight
        lat = 5;
        redirect(32'h380);
        n = 0;
        while (pend.size() != 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("three_outstanding", 96'(pend.size()), 96'(3));
        redirect(32'h100);
        lat = 0;
        expect_ins(64'h410, 32'h100);
        expect_ins(64'h420, 32'h104);
        expect_ins(64'h430, 32'h108);
        drain("t4", 60);

        // Bus error becomes a precise fault
        err_adr = 32'h8;
        redirect(32'h0);
        expect_ins(64'h10, 32'h0);
        expect_ins(64'h20, 32'h4);
        drain("t5", 40);
        stall_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("fault_set", 96'(fault), 96'(1));
        chk("fault_adr", 96'(fault_adr), 96'(32'h8));
        chk("fault_stb_cyc", 96'({bus_if.stb, bus_if.cyc}), 96'(0));
        chk("fault_no_ir", 96'(ir_valid), 96'(0));
        stall_i = 1'b1;
        err_adr = 32'hFFFF_FFFF;
        redirect(32'h40);
        chk("fault_clear", 96'(fault), 96'(0));
        expect_ins(64'h110, 32'h40);
        expect_ins(64'h120, 32'h44);
        drain("t5b", 40);

        // Redirect under stall in the same cycle as an ack
        redirect(32'h500);
        n = 0;
        while (!bus_if.ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ack_before_set", 96'(bus_if.ack), 96'(1));
        redirect(32'h600);
        chk("set_clears_valid", 96'(ir_valid), 96'(0));
        expect_ins(64'h1810, 32'h600);
        expect_ins(64'h1820, 32'h604);
        drain("t6", 40);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
